tlb_refill: RTL and testbench

Hardware TLB refill controller that sits beside the 8-entry TLB and owns its write and clear ports. It arbitrates between the fetch-side (port 0) and memory-side (port 1) TLB-miss requests. For the winner it walks a single-level page table in memory, then writes the translation into the TLB or reports a page fault or walk timeout to the requester. It stalls nothing itself; requesters hold their miss request until they see a done pulse.

---
 rtl/tlb_refill.sv | 190 +++++++++++++++++++
 tb/tb_tlb_refill.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tlb_refill.sv
// tlb_refill: TLB refill controller. Arbitrates fetch/memory-side misses,
// walks a single-level page table and writes the translation into the TLB,
// or reports a page fault / walk timeout to the requesting port.
module tlb_refill #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [11:0] pid,
  input  logic [31:0] ptbr,
  input  logic        miss0,
  input  logic [31:0] vaddr0,
  input  logic        miss1,
  input  logic [31:0] vaddr1,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        tlb_we,
  output logic [31:0] tlb_key,
  output logic [31:0] tlb_wdata,
  output logic        tlb_clear,
  output logic        busy,
  output logic        done0,
  output logic        done1,
  output logic        fault,
  output logic [7:0]  fault_code
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WALK  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic        side_q, side_d;          // 1 = memory-side port
  logic [31:0] key_q, key_d;
  logic [31:0] addr_q, addr_d;
  logic [5:0]  ppn_q, ppn_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        abort_q, abort_d;

  logic        mem_req_q, mem_req_d;
  logic        tlb_we_q, tlb_we_d;
  logic        tlb_clear_q, tlb_clear_d;
  logic        busy_q, busy_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        fault_q, fault_d;
  logic [7:0]  fault_code_q, fault_code_d;

  logic [19:0] vpn_s;
  logic        abort_now_s;

  // Only the page number of the virtual address and the PTE's valid/PPN bits matter.
  logic unused_s;
  assign unused_s = ^{vaddr0[11:0], vaddr1[11:0], mem_rdata[30:6]};

  // Next-state logic and the next value of every registered output.
  always_comb begin
    state_d      = state_q;
    side_d       = side_q;
    key_d        = key_q;
    addr_d       = addr_q;
    ppn_d        = ppn_q;
    cnt_d        = cnt_q;
    abort_d      = abort_q;
    fault_code_d = 8'h00;
    vpn_s        = miss1 ? vaddr1[31:12] : vaddr0[31:12];
    // A flush arriving in the ack cycle aborts the walk just like an earlier one.
    abort_now_s  = abort_q | flush;

    case (state_q)
      S_IDLE: begin
        if (!flush && (miss0 || miss1)) begin
          side_d  = miss1;              // port 1 holds the older instruction
          key_d   = {pid, vpn_s};
          addr_d  = ptbr + {10'b0, vpn_s, 2'b00};
          cnt_d   = 8'd0;
          abort_d = 1'b0;
          state_d = S_WALK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WALK: begin
        if (flush) begin
          abort_d = 1'b1;
        end else begin
          abort_d = abort_q;
        end
        if (mem_ack) begin
          ppn_d = mem_rdata[5:0];
          if (abort_now_s) begin
            state_d = S_IDLE;
          end else if (mem_rdata[31]) begin
            state_d = S_WRITE;
          end else begin
            state_d      = S_FAULT;
            fault_code_d = 8'h84;
          end
        end else if (cnt_q == MAX_WAIT_C) begin
          if (abort_now_s) begin
            state_d = S_IDLE;
          end else begin
            state_d      = S_FAULT;
            fault_code_d = 8'h85;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WRITE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_req_d   = (state_d == S_WALK);
    tlb_we_d    = (state_d == S_WRITE);
    busy_d      = (state_d != S_IDLE);
    fault_d     = (state_d == S_FAULT);
    done0_d     = ((state_d == S_DONE) || (state_d == S_FAULT)) && !side_d;
    done1_d     = ((state_d == S_DONE) || (state_d == S_FAULT)) && side_d;
    tlb_clear_d = flush;
  end

  // State, walk context and registered outputs; everything holds while clk_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      side_q       <= 1'b0;
      key_q        <= 32'h0;
      addr_q       <= 32'h0;
      ppn_q        <= 6'h0;
      cnt_q        <= 8'h0;
      abort_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      tlb_we_q     <= 1'b0;
      tlb_clear_q  <= 1'b0;
      busy_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 8'h00;
    end else if (clk_en) begin
      state_q      <= state_d;
      side_q       <= side_d;
      key_q        <= key_d;
      addr_q       <= addr_d;
      ppn_q        <= ppn_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
      mem_req_q    <= mem_req_d;
      tlb_we_q     <= tlb_we_d;
      tlb_clear_q  <= tlb_clear_d;
      busy_q       <= busy_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = addr_q;
  assign tlb_we     = tlb_we_q;
  assign tlb_key    = key_q;
  assign tlb_wdata  = {26'b0, ppn_q};
  assign tlb_clear  = tlb_clear_q;
  assign busy       = busy_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_tlb_refill.sv
// Directed self-checking bench for tlb_refill (MAX_WAIT = 4).
module tb_tlb_refill;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic [11:0] pid = 12'h0;
  logic [31:0] ptbr = 32'h0;
  logic        miss0 = 1'b0;
  logic [31:0] vaddr0 = 32'h0;
  logic        miss1 = 1'b0;
  logic [31:0] vaddr1 = 32'h0;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        tlb_we;
  logic [31:0] tlb_key;
  logic [31:0] tlb_wdata;
  logic        tlb_clear;
  logic        busy;
  logic        done0;
  logic        done1;
  logic        fault;
  logic [7:0]  fault_code;

  int vectors = 0;
  int miscompares = 0;

  tlb_refill #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .pid(pid), .ptbr(ptbr),
    .miss0(miss0), .vaddr0(vaddr0), .miss1(miss1), .vaddr1(vaddr1),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .tlb_we(tlb_we),
    .tlb_key(tlb_key), .tlb_wdata(tlb_wdata), .tlb_clear(tlb_clear),
    .busy(busy), .done0(done0), .done1(done1), .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int we_cnt;
    int req_cnt;
    int clr_cnt;
    int done_cnt;
    int first_done;
    int seen0;
    int seen1;
    int found;

    // ---- reset ----
    tick();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_outs", {tlb_we, tlb_clear, busy, done0, done1, fault}, 32'd0);
    chk("rst_key_wdata", tlb_key | tlb_wdata, 32'd0);
    chk("rst_fcode", {24'b0, fault_code}, 32'd0);
    rst = 1'b0;
    tick();

    // ---- basic refill ----
    pid = 12'h003; ptbr = 32'h0001_0000;
    vaddr0 = 32'h0040_2ABC; miss0 = 1'b1;
    tick();
    chk("basic_req", {31'b0, mem_req}, 32'd1);
    chk("basic_addr", mem_addr, 32'h0001_1008);
    chk("basic_busy", {31'b0, busy}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h8000_0015;
    tick();
    mem_ack = 1'b0;
    chk("basic_we", {31'b0, tlb_we}, 32'd1);
    chk("basic_key", tlb_key, 32'h0030_0402);
    chk("basic_wdata", tlb_wdata, 32'h0000_0015);
    chk("basic_req_drop", {31'b0, mem_req}, 32'd0);
    tick();
    chk("basic_done", {tlb_we, done0, done1, fault}, {28'd0, 4'b0100});
    miss0 = 1'b0;
    tick();
    chk("basic_idle", {busy, done0}, 32'd0);

    // ---- arbitration: both ports miss together ----
    vaddr0 = 32'h0040_2ABC; vaddr1 = 32'h1234_5678;
    miss0 = 1'b1; miss1 = 1'b1;
    tick();
    chk("arb_addr_p1", mem_addr, 32'h0005_8D14);
    mem_ack = mem_req; mem_rdata = 32'h8000_0021;
    we_cnt = 0; first_done = 0; seen0 = 0; seen1 = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tlb_we) we_cnt++;
      if (done1 && first_done == 0) first_done = 1;
      if (done0 && first_done == 0) first_done = 2;
      if (done1) begin seen1++; miss1 = 1'b0; end
      if (done0) begin seen0++; miss0 = 1'b0; end
      mem_ack = mem_req;
    end
    mem_ack = 1'b0;
    chk("arb_first_port1", first_done, 1);
    chk("arb_we_pulses", we_cnt, 2);
    chk("arb_done_each", {seen0[15:0], seen1[15:0]}, {16'd1, 16'd1});

    // ---- invalid PTE ----
    vaddr1 = 32'h0000_5000; miss1 = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0015;
    tick();
    mem_ack = 1'b0;
    chk("inv_flags", {tlb_we, done0, done1, fault}, {28'd0, 4'b0011});
    chk("inv_code", {24'b0, fault_code}, 32'h84);
    miss1 = 1'b0;
    tick();
    chk("inv_clear", {16'b0, fault_code, 5'b0, busy, done1, fault}, 32'd0);

    // ---- timeout (MAX_WAIT = 4) ----
    vaddr0 = 32'h0000_1000; miss0 = 1'b1;
    tick();
    miss0 = 1'b0;
    req_cnt = 0; found = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) req_cnt++;
      if (done0) begin
        found = 1;
        chk("to_fault", {30'b0, fault, tlb_we}, 32'd2);
        chk("to_code", {24'b0, fault_code}, 32'h85);
        break;
      end
      tick();
    end
    chk("to_done_seen", found, 1);
    chk("to_req_cycles", req_cnt, 5);
    tick();

    // ---- flush mid-walk ----
    vaddr0 = 32'h0000_2000; miss0 = 1'b1;
    tick();
    miss0 = 1'b0;
    clr_cnt = 0; we_cnt = 0; done_cnt = 0; req_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) tick();
      if (tlb_clear) clr_cnt++;
      if (tlb_we) we_cnt++;
      if (done0 || done1) done_cnt++;
      if (mem_req) req_cnt++;
      if (i == 5) chk("fl_req_held", {31'b0, mem_req}, 32'd1);
      if (i == 6) chk("fl_idle_after_ack", {30'b0, busy, mem_req}, 32'd0);
      flush = (i == 2);
      mem_ack = (i == 5);
    end
    chk("fl_clear_once", clr_cnt, 1);
    chk("fl_no_we_done", we_cnt + done_cnt, 0);
    chk("fl_req_cycles", req_cnt, 5);

    // ---- async reset mid-walk ----
    vaddr1 = 32'h0000_3000; miss1 = 1'b1;
    tick();
    miss1 = 1'b0;
    chk("rw_walking", {30'b0, busy, mem_req}, 32'd3);
    #3;
    rst = 1'b1;
    #1;
    chk("rw_drop", {26'b0, mem_req, busy, tlb_we, done0, done1, fault}, 32'd0);
    chk("rw_addr", mem_addr | tlb_key, 32'd0);
    tick();
    rst = 1'b0;
    vaddr0 = 32'h0040_2ABC; miss0 = 1'b1;
    tick();
    chk("rw_fresh_addr", mem_addr, 32'h0001_1008);
    chk("rw_fresh_req", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h8000_0007;
    tick();
    mem_ack = 1'b0;
    chk("rw_we", {tlb_we, tlb_wdata[30:0]}, {1'b1, 31'd7});
    tick();
    miss0 = 1'b0;
    chk("rw_done", {30'b0, done0, fault}, 32'd2);

    // ---- clk_en low stretches the done pulse ----
    clk_en = 1'b0;
    tick();
    chk("ce_hold", {30'b0, done0, busy}, 32'd3);
    clk_en = 1'b1;
    tick();
    chk("ce_release", {30'b0, done0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard bound on the run in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "bench timeout");
  end

endmodule
